// File: rtl/nec_rx_pkg.sv
// NEC infrared receiver: shared FSM state type, nominal protocol
// durations and the helpers that turn them into cycle thresholds.
package nec_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LO,
        LEAD_HI,
        BIT_LO,
        BIT_HI,
        REP_STOP
    } state_t;

    // Nominal durations in microseconds, scaled by 10 so 562.5 us stays integral.
    localparam longint LEAD_LO_US_X10  = 90000;   // 9.0 ms
    localparam longint LEAD_HI_US_X10  = 45000;   // 4.5 ms, data frame
    localparam longint REP_HI_US_X10   = 22500;   // 2.25 ms, repeat code
    localparam longint BIT_LO_US_X10   = 5625;    // 562.5 us burst
    localparam longint BIT_ZERO_US_X10 = 5625;    // 562.5 us space -> 0
    localparam longint BIT_ONE_US_X10  = 16875;   // 1687.5 us space -> 1

    function automatic int us_x10_to_cycles(input longint clk_hz, input longint us_x10);
        return int'(clk_hz * us_x10 / 10_000_000);
    endfunction

    function automatic int win_min(input int nom, input int tol_pct);
        return int'(longint'(nom) * (100 - tol_pct) / 100);
    endfunction

    function automatic int win_max(input int nom, input int tol_pct);
        return int'(longint'(nom) * (100 + tol_pct) / 100);
    endfunction

    function automatic logic in_win(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/nec_rx_sync.sv
// Two-flop synchronizer for the raw IR pin, followed by an optional
// run-length glitch filter (enabled by NEC_RX_GLITCH_FILTER_EN).
module nec_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic raw,
    output logic level
);

    logic [1:0] sync_ff;

    // Bring the asynchronous pin into the clock domain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[0], raw};
        end
    end

`ifdef NEC_RX_GLITCH_FILTER_EN
    logic [2:0] run_cnt;
    logic       filt;

    // Follow the synchronized line only after 8 consecutive differing samples.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            run_cnt <= '0;
            filt    <= 1'b0;
        end else if (sync_ff[1] == filt) begin
            run_cnt <= '0;
        end else if (run_cnt == 3'd7) begin
            filt    <= sync_ff[1];
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 3'd1;
        end
    end

    assign level = filt;
`else
    assign level = sync_ff[1];
`endif

endmodule

// File: rtl/nec_rx_core.sv
// NEC IR frame/repeat decoder. Measures each synchronized level with a
// saturating counter and walks the protocol with a two-process FSM.
// Optional glitch filter in the front end: define NEC_RX_GLITCH_FILTER_EN.
module nec_rx_core
    import nec_rx_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TOL_PCT       = 20,
    parameter int EXT_ADDR      = 0,
    parameter int REPEAT_WIN_MS = 110
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        infrared_in,
    output logic [15:0] addr,
    output logic [7:0]  cmd,
    output logic        data_valid,
    output logic        repeat_code,
    output logic        err,
    output logic        busy
);

    localparam int LL_NOM = us_x10_to_cycles(CLK_HZ, LEAD_LO_US_X10);
    localparam int LL_MIN = win_min(LL_NOM, TOL_PCT);
    localparam int LL_MAX = win_max(LL_NOM, TOL_PCT);
    localparam int LH_NOM = us_x10_to_cycles(CLK_HZ, LEAD_HI_US_X10);
    localparam int LH_MIN = win_min(LH_NOM, TOL_PCT);
    localparam int LH_MAX = win_max(LH_NOM, TOL_PCT);
    localparam int RH_NOM = us_x10_to_cycles(CLK_HZ, REP_HI_US_X10);
    localparam int RH_MIN = win_min(RH_NOM, TOL_PCT);
    localparam int RH_MAX = win_max(RH_NOM, TOL_PCT);
    localparam int BL_NOM = us_x10_to_cycles(CLK_HZ, BIT_LO_US_X10);
    localparam int BL_MIN = win_min(BL_NOM, TOL_PCT);
    localparam int BL_MAX = win_max(BL_NOM, TOL_PCT);
    localparam int B0_NOM = us_x10_to_cycles(CLK_HZ, BIT_ZERO_US_X10);
    localparam int B0_MIN = win_min(B0_NOM, TOL_PCT);
    localparam int B0_MAX = win_max(B0_NOM, TOL_PCT);
    localparam int B1_NOM = us_x10_to_cycles(CLK_HZ, BIT_ONE_US_X10);
    localparam int B1_MIN = win_min(B1_NOM, TOL_PCT);
    localparam int B1_MAX = win_max(B1_NOM, TOL_PCT);

    // Counter saturates at the longest acceptable leader burst.
    localparam int                CNT_W   = $clog2(LL_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(LL_MAX);
    localparam int                REP_CYC = int'(longint'(CLK_HZ) * REPEAT_WIN_MS / 1000);
    localparam int                REP_W   = $clog2(REP_CYC + 1);
    localparam logic [REP_W-1:0]  REP_LOAD = REP_W'(REP_CYC);

    logic             level;
    logic             level_d;
    logic             rise;
    logic             fall;
    logic             edge_any;
    logic [CNT_W-1:0] cnt;
    int               cnt_i;
    logic             sat;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      shreg;
    logic [5:0]       bit_idx;
    logic [REP_W-1:0] rep_tmr;
    logic             rep_running;
    logic             frame_ok;

    logic             dv_nxt;
    logic             rep_nxt;
    logic             err_nxt;
    logic             shift_en;
    logic             shift_bit;
    logic             idx_clr;
    logic             frame_load;

    nec_rx_sync u_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .raw     (infrared_in),
        .level   (level)
    );

    assign rise        = level & ~level_d;
    assign fall        = ~level & level_d;
    assign edge_any    = rise | fall;
    assign cnt_i       = 32'(cnt);
    assign sat         = (cnt == CNT_SAT);
    assign rep_running = (rep_tmr != '0);
    assign busy        = (state != IDLE);

    // Inverse-byte checks; the extended variant accepts any 16-bit address.
    assign frame_ok = (shreg[31:24] == ~shreg[23:16]) &&
                      ((EXT_ADDR != 0) || (shreg[15:8] == ~shreg[7:0]));

    // Edge detection and duration of the current level, restarting at every edge.
    // NOTE: a synchronous reset clears every register here, including the data path.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            level_d <= level;
            if (edge_any) begin
                cnt <= CNT_W'(1);
            end else if (!sat) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Protocol walk: decide next state and which action/pulse the deciding edge triggers.
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        state_nxt  = state;
        dv_nxt     = 1'b0;
        rep_nxt    = 1'b0;
        err_nxt    = 1'b0;
        shift_en   = 1'b0;
        shift_bit  = 1'b0;
        idx_clr    = 1'b0;
        frame_load = 1'b0;
        case (state)
            IDLE: begin
                if (fall) state_nxt = LEAD_LO;
            end
            LEAD_LO: begin
                if (rise) begin
                    if (in_win(cnt_i, LL_MIN, LL_MAX)) begin
                        state_nxt = LEAD_HI;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (sat) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            LEAD_HI: begin
                if (fall) begin
                    if (in_win(cnt_i, LH_MIN, LH_MAX)) begin
                        idx_clr   = 1'b1;
                        state_nxt = BIT_LO;
                    end else if (in_win(cnt_i, RH_MIN, RH_MAX)) begin
                        state_nxt = REP_STOP;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (sat) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BIT_LO: begin
                if (rise) begin
                    if (!in_win(cnt_i, BL_MIN, BL_MAX)) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (bit_idx == 6'd32) begin
                        // Stop burst: the frame is complete.
                        if (frame_ok) begin
                            frame_load = 1'b1;
                            dv_nxt     = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = BIT_HI;
                    end
                end else if (sat) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BIT_HI: begin
                if (fall) begin
                    if (in_win(cnt_i, B0_MIN, B0_MAX)) begin
                        shift_en  = 1'b1;
                        state_nxt = BIT_LO;
                    end else if (in_win(cnt_i, B1_MIN, B1_MAX)) begin
                        shift_en  = 1'b1;
                        shift_bit = 1'b1;
                        state_nxt = BIT_LO;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (sat) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            REP_STOP: begin
                if (rise) begin
                    if (in_win(cnt_i, BL_MIN, BL_MAX) && rep_running) begin
                        rep_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end else if (sat) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, bit collection, decoded outputs and registered result pulses.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_idx     <= '0;
            addr        <= '0;
            cmd         <= '0;
            data_valid  <= 1'b0;
            repeat_code <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            data_valid  <= dv_nxt;
            repeat_code <= rep_nxt;
            err         <= err_nxt;
            if (idx_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                // LSB-first: the first received bit ends up in bit 0.
                shreg   <= {shift_bit, shreg[31:1]};
                bit_idx <= bit_idx + 6'd1;
            end
            if (frame_load) begin
                if (EXT_ADDR != 0) begin
                    addr <= shreg[15:0];
                end else begin
                    addr <= {8'h00, shreg[7:0]};
                end
                cmd <= shreg[23:16];
            end
        end
    end

    // Repeat acceptance window, re-armed by every accepted frame or repeat.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rep_tmr <= '0;
        end else if (data_valid || repeat_code) begin
            rep_tmr <= REP_LOAD;
        end else if (rep_running) begin
            rep_tmr <= rep_tmr - REP_W'(1);
        end
    end

endmodule
